// File: rtl/rv64g_pkg.sv
// Shared RV64G core types and constants used by the register-lock arbitration logic.
package rv64g_pkg;

  localparam int NUM_REGS             = 32;
  localparam int REG_LOCK_ARB_NUM_REQ = 4;

  typedef logic [NUM_REGS-1:0] reg_mask_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin one-hot arbiter that owns its pointer; grant is combinational (0 cycles).
// No backpressure of its own: losers simply see gnt=0 and retry; the pointer moves only on a granted, advancing cycle.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam logic [PW:0]   NW   = (PW+1)'(N);
  localparam logic [PW-1:0] LAST = PW'(N-1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;
  logic          found;

  // Scan from ptr upward, wrapping modulo N; first requester found wins.
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    sum     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= NW) sum = sum - NW;
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
    end
  end

endmodule

// File: rtl/reg_lock_arb.sv
// Register scoreboard owner: grants one lock-set per cycle round-robin (0-cycle grant, lock visible next cycle);
// blocked or flushed requesters just see no grant. Optional conflict-stall counter under REG_LOCK_ARB_PERF_EN.
module reg_lock_arb
  import rv64g_pkg::*;
#(
  parameter  int NREQ = REG_LOCK_ARB_NUM_REQ,
  localparam int NR   = NUM_REGS
) (
  input  logic [0:0]         clk_i,
  input  logic [0:0]         arst_ni,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*NR-1:0] lock_mask_i,
  output logic [NREQ-1:0]    gnt_o,
  input  logic [NR-1:0]      unlock_i,
  input  logic [0:0]         flush_i,
  output logic [NR-1:0]      locks_o
`ifdef REG_LOCK_ARB_PERF_EN
  ,
  output logic [31:0]        stall_cnt_o
`endif
);

  reg_mask_t         locks_q;
  reg_mask_t         locks_d;
  reg_mask_t         masks     [NREQ];
  reg_mask_t         set_chain [NREQ+1];
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   arb_req;

  // Eligibility looks only at the registered locks: a same-cycle unlock is not bypassed.
  assign set_chain[0] = '0;
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign masks[i]       = lock_mask_i[i*NR +: NR];
    assign elig[i]        = req_i[i] & ~|(masks[i] & locks_q);
    assign set_chain[i+1] = set_chain[i] | (gnt_o[i] ? masks[i] : '0);
  end

  // Requests are squashed while in reset or flushing so no grant can escape.
  assign arb_req = elig & {NREQ{arst_ni[0] & ~flush_i[0]}};

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk_i   (clk_i[0]),
    .arst_ni (arst_ni[0]),
    .req     (arb_req),
    .advance (~flush_i[0]),
    .gnt     (gnt_o)
  );

  always_comb begin
    locks_d    = (locks_q & ~unlock_i) | set_chain[NREQ];
    locks_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i[0] or negedge arst_ni[0]) begin
    if (!arst_ni[0]) begin
      locks_q <= '0;
    end else if (flush_i[0]) begin
      locks_q <= '0;
    end else begin
      locks_q <= locks_d;
    end
  end

  assign locks_o = locks_q;

`ifdef REG_LOCK_ARB_PERF_EN
  // Counts cycles where someone wanted a lock but was blocked by a conflict; saturates.
  always_ff @(posedge clk_i[0] or negedge arst_ni[0]) begin
    if (!arst_ni[0]) begin
      stall_cnt_o <= '0;
    end else if (|req_i && !(|gnt_o) && !flush_i[0] && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_lock_arb.sv
// Self-checking bench for reg_lock_arb: directed scenarios plus random traffic against a behavioural scoreboard model.
module tb_reg_lock_arb;
  import rv64g_pkg::*;

  localparam int NREQ = 4;
  localparam int NR   = NUM_REGS;

  logic                 clk_i   = 1'b0;
  logic                 arst_ni = 1'b1;
  logic [NREQ-1:0]      req_i   = '0;
  logic [NREQ*NR-1:0]   lock_mask_i = '0;
  logic [NREQ-1:0]      gnt_o;
  logic [NR-1:0]        unlock_i = '0;
  logic                 flush_i  = 1'b0;
  logic [NR-1:0]        locks_o;
`ifdef REG_LOCK_ARB_PERF_EN
  logic [31:0]          stall_cnt_o;
  logic [31:0]          cnt0;
`endif

  reg_lock_arb #(.NREQ(NREQ)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .req_i       (req_i),
    .lock_mask_i (lock_mask_i),
    .gnt_o       (gnt_o),
    .unlock_i    (unlock_i),
    .flush_i     (flush_i),
    .locks_o     (locks_o)
`ifdef REG_LOCK_ARB_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the set of locked registers and whose turn it is.
  logic [NR-1:0]   m [NREQ];
  logic [NR-1:0]   mdl_locks;
  int              mdl_ptr;
  logic [NREQ-1:0] obs_gnt;
  logic [NR-1:0]   obs_locks;
  logic [NREQ-1:0] act;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] rq, input logic fl);
    int i;
    if (fl) return -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (mdl_ptr + k) % NREQ;
      if (rq[i] && ((m[i] & mdl_locks) == '0)) return i;
    end
    return -1;
  endfunction

  task automatic step(input logic [NREQ-1:0] rq, input logic [NR-1:0] unl, input logic fl);
    int g;
    logic [NREQ-1:0] eg;
    @(negedge clk_i);
    req_i    = rq;
    unlock_i = unl;
    flush_i  = fl;
    for (int i = 0; i < NREQ; i++) lock_mask_i[i*NR +: NR] = m[i];
    #1;
    g  = pick(rq, fl);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    obs_gnt   = gnt_o;
    obs_locks = locks_o;
    check("gnt", 64'(gnt_o), 64'(eg));
    check("locks", 64'(locks_o), 64'(mdl_locks));
    @(posedge clk_i);
    if (fl) begin
      mdl_locks = '0;
    end else begin
      mdl_locks    = (mdl_locks & ~unl) | ((g >= 0) ? m[g] : '0);
      mdl_locks[0] = 1'b0;
    end
    if (g >= 0) mdl_ptr = (g + 1) % NREQ;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2;
    req_i   = '1;
    arst_ni = 1'b0;
    #1;
    check("rst_gnt", 64'(gnt_o), 64'(0));
    check("rst_locks", 64'(locks_o), 64'(0));
    mdl_locks = '0;
    mdl_ptr   = 0;
    act       = '0;
    req_i     = '0;
    @(negedge clk_i);
    arst_ni = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] unl;
    logic [NR-1:0] bm;
    logic          fl;
    for (int i = 0; i < NREQ; i++) m[i] = '0;
    mdl_locks = '0;
    mdl_ptr   = 0;
    act       = '0;

    // Reset with all requests high: no grant, no locks.
    #1;
    arst_ni = 1'b0;
    req_i   = '1;
    lock_mask_i = {NREQ{32'h0000_00F0}};
    #3;
    check("rst0_gnt", 64'(gnt_o), 64'(0));
    check("rst0_locks", 64'(locks_o), 64'(0));
    req_i = '0;
    @(negedge clk_i);
    arst_ni = 1'b1;

    // Grant is same-cycle, lock visible one cycle later.
    m[0] = NR'(1) << 5;
    step(4'b0001, '0, 1'b0);
    check("t1_gnt", 64'(obs_gnt), 64'(4'b0001));
    step(4'b0000, '0, 1'b0);
    check("t1_lock5", 64'(obs_locks[5]), 64'(1));

    // Unlock, and set-wins when unlock and set hit the same bit.
    step(4'b0000, NR'(1) << 5, 1'b0);
    step(4'b0000, '0, 1'b0);
    check("t2_unlock5", 64'(obs_locks[5]), 64'(0));
    m[1] = NR'(1) << 3;
    step(4'b0010, NR'(1) << 3, 1'b0);
    step(4'b0000, '0, 1'b0);
    check("t2_setwins3", 64'(obs_locks[3]), 64'(1));
    step(4'b0000, '1, 1'b0);

    // Round-robin rotation and wrap from a fresh pointer.
    do_reset();
    for (int i = 0; i < NREQ; i++) m[i] = NR'(1) << (i + 1);
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, '1, 1'b0);
      check("t3_rr", 64'(obs_gnt), 64'(1 << (k % NREQ)));
    end
    step(4'b0000, '1, 1'b0);

    // Conflict: locked requester skipped; no same-cycle unlock bypass.
    m[0] = NR'(1) << 7;
    step(4'b0001, '0, 1'b0);
    m[1] = NR'(1) << 7;
    m[2] = NR'(1) << 9;
    step(4'b0110, '0, 1'b0);
    check("t4_skip", 64'(obs_gnt), 64'(4'b0100));
    step(4'b0010, NR'(1) << 7, 1'b0);
    check("t4_nobypass", 64'(obs_gnt), 64'(0));
    step(4'b0010, '0, 1'b0);
    check("t4_late", 64'(obs_gnt), 64'(4'b0010));

    // x0 never locks; flush blocks grant, clears locks, keeps pointer.
    step(4'b0000, '1, 1'b0);
    m[0] = NR'(1) | (NR'(1) << 6);
    step(4'b0001, '0, 1'b0);
    step(4'b0000, '0, 1'b0);
    check("t5_x0", 64'(obs_locks), 64'(32'h0000_0040));
    m[0] = NR'(1) << 10;
    m[1] = NR'(1) << 11;
    step(4'b0011, '0, 1'b1);
    check("t5_flush_gnt", 64'(obs_gnt), 64'(0));
    step(4'b0011, '0, 1'b0);
    check("t5_flush_locks", 64'(obs_locks), 64'(0));
    check("t5_ptr_hold", 64'(obs_gnt), 64'(4'b0010));
    step(4'b0000, '1, 1'b0);

`ifdef REG_LOCK_ARB_PERF_EN
    m[0] = NR'(1) << 12;
    step(4'b0001, '0, 1'b0);
    #1;
    cnt0 = stall_cnt_o;
    m[1] = NR'(1) << 12;
    for (int k = 0; k < 10; k++) step(4'b0010, '0, 1'b0);
    #1;
    check("t6_stall", 64'(stall_cnt_o - cnt0), 64'(10));
    step(4'b0000, '1, 1'b0);
`endif

    // Random traffic under the requester hold-until-grant handshake.
    act = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 500 == 499) do_reset();
      for (int i = 0; i < NREQ; i++) begin
        if (act[i] && $urandom_range(19) == 0) begin
          act[i] = 1'b0;
        end else if (!act[i] && $urandom_range(2) == 0) begin
          act[i] = 1'b1;
          bm = NR'(1) << $urandom_range(11);
          if ($urandom_range(1) == 1) bm = bm | (NR'(1) << $urandom_range(11));
          if ($urandom_range(7) == 0) bm = '0;
          m[i] = bm;
        end
      end
      unl = ($urandom_range(3) == 0) ? (NR'($urandom) & NR'(32'h0000_0FFF)) : '0;
      fl  = ($urandom_range(49) == 0);
      step(act, unl, fl);
      act = act & ~obs_gnt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
